// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte/word helpers shared by the key schedule datapath.
package aes_pkg;

    typedef enum logic [1:0] {KS_IDLE, KS_FWD, KS_REV} ks_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] SubWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] RotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] RCON(input int j);
        case (j)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] InvMixColumnsWord(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // f term of the expansion recurrence; idx is the index of the word being produced
    function automatic logic [31:0] KeyTemp(input logic [31:0] w, input logic [5:0] idx, input int nk);
        int i;
        i = int'(idx);
        if (i % nk == 0) return SubWord(RotWord(w)) ^ {RCON(i / nk), 24'h000000};
        if (nk > 6 && i % nk == 4) return SubWord(w);
        return w;
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// rtl/aes_key_word_step.sv - one key-expansion word step, usable forwards or backwards.
module aes_key_word_step
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [31:0] w_far,
    input  logic [31:0] w_near,
    input  logic [5:0]  idx,
    output logic [31:0] w_next
);

    assign w_next = w_far ^ KeyTemp(w_near, idx, NK);

endmodule

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - round keys Nr..0 from an Nk-word sliding window.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int Nk     = 4,
    parameter int Nr     = Nk + 6,
    parameter bit EQ_INV = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [32*Nk-1:0]  key,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last
);

    localparam logic [5:0] NK6       = 6'(Nk);
    localparam logic [5:0] LAST_BASE = 6'(4 * (Nr + 1) - 1 - Nk);
    localparam logic [3:0] NR4       = 4'(Nr);

    ks_state_e     r_state;
    logic [31:0]   r_win [Nk];
    logic [5:0]    r_base;
    logic [3:0]    r_pend;
    logic          r_busy;
    logic          r_valid;
    logic          r_last;
    logic [3:0]    r_round;
    logic [127:0]  r_data;

    logic          w_rev;
    logic [31:0]   w_far;
    logic [31:0]   w_near;
    logic [31:0]   w_new;
    logic [5:0]    w_idx;
    logic [5:0]    w_lo;
    logic          w_in_win;
    logic [127:0]  w_rk;

    // r_win[k] holds w[r_base+k]; forward appends at the top, reverse at the bottom
    assign w_rev  = (r_state == KS_REV);
    assign w_far  = w_rev ? r_win[Nk-1] : r_win[0];
    assign w_near = w_rev ? r_win[Nk-2] : r_win[Nk-1];
    assign w_idx  = w_rev ? (r_base + NK6 - 6'd1) : (r_base + NK6);

    aes_key_word_step #(.NK(Nk)) u_step (
        .w_far  (w_far),
        .w_near (w_near),
        .idx    (w_idx),
        .w_next (w_new)
    );

    assign w_lo     = {r_pend, 2'b00};
    assign w_in_win = (w_lo >= r_base) && (w_lo + 6'd3 <= r_base + NK6 - 6'd1);

    always_comb begin
        w_rk = '0;
        for (int k = 0; k <= Nk - 4; k++) begin
            if (w_lo - r_base == 6'(k)) w_rk = {r_win[k+3], r_win[k+2], r_win[k+1], r_win[k]};
        end
        if (EQ_INV && r_pend != 4'd0 && r_pend != NR4) begin
            for (int j = 0; j < 4; j++) w_rk[32*j +: 32] = InvMixColumnsWord(w_rk[32*j +: 32]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KS_IDLE;
            r_base  <= 6'd0;
            r_pend  <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_round <= 4'd0;
            r_data  <= '0;
            for (int k = 0; k < Nk; k++) r_win[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < Nk; k++) r_win[k] <= key[32*k +: 32];
            r_state <= KS_FWD;
            r_base  <= 6'd0;
            r_pend  <= NR4;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                KS_FWD: begin
                    for (int k = 0; k < Nk - 1; k++) r_win[k] <= r_win[k+1];
                    r_win[Nk-1] <= w_new;
                    r_base      <= r_base + 6'd1;
                    if (r_base == LAST_BASE) r_state <= KS_REV;
                end
                KS_REV: begin
                    if (r_valid) begin
                        if (rk_ready) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_pend  <= r_pend - 4'd1;
                            if (r_round == 4'd0) begin
                                r_state <= KS_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else if (w_in_win) begin
                        r_data  <= w_rk;
                        r_round <= r_pend;
                        r_last  <= (r_pend == 4'd0);
                        r_valid <= 1'b1;
                    end else begin
                        for (int k = Nk - 1; k > 0; k--) r_win[k] <= r_win[k-1];
                        r_win[0] <= w_new;
                        r_base   <= r_base - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign rk_valid = r_valid;
    assign rk_data  = r_data;
    assign rk_round = r_round;
    assign rk_last  = r_last;

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Iterative key schedule for the decryption datapath. It produces round keys in reverse order, Nr down to 0, as 128-bit words on a valid/ready stream.
- On load it runs the forward expansion one word per cycle, keeping only an Nk-word window. It then walks the recurrence backwards, w[i-Nk] = w[i] ^ f(w[i-1]), emitting each round key once its 4 words are in the window.
- This replaces the fully unrolled all-rounds key store on the decrypt side and needs O(Nk) words of storage.

Parameters:
- Nk, 4, key length in 32-bit words (4, 6 or 8).
- Nr, Nk+6, number of rounds.
- EQ_INV, 0, when 1 apply InvMixColumns to each word of rounds 1..Nr-1 on output (equivalent inverse cipher form).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  start a new schedule with key; accepted in any state.
- key  in  32*Nk  cipher key; word i at key[32*i+:32].
- busy  out  1  high from the cycle after load until the round-0 handshake.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts.
- rk_data  out  128  round key; rk_data[32*j+:32] = w[4*rk_round+j].
- rk_round  out  4  round index of rk_data.
- rk_last  out  1  high with rk_valid when rk_round==0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state IDLE; busy=0, rk_valid=0, rk_last=0, rk_round=0, rk_data=0, window cleared.
- Word order and byte convention follow aes_pkg SubWord/RotWord/RCON.
- FSM IDLE -> FWD -> REV -> IDLE.
- IDLE, load=1: capture key into window w[0..Nk-1], set i=Nk, go to FWD.
- FWD: per cycle compute w[i] with the standard rule (i%Nk==0: SubWord(RotWord)^RCON[i/Nk]; Nk>6 and i%Nk==4: SubWord; else XOR). Shift the window, i++.
- FWD exits to REV after the cycle producing w[4*(Nr+1)-1]. That is 40/46/52 FWD cycles for Nk=4/6/8.
- REV: pending round r starts at Nr. Window covers w[b..b+Nk-1].
  - If 4r >= b and 4r+3 <= b+Nk-1: register rk_data/rk_round and assert rk_valid next cycle.
  - Otherwise do one backward step per cycle: w[b-1] = w[b-1+Nk] ^ f(w[b-2+Nk]), f chosen by index b-1+Nk. Drop the top word, b--.
- No backward step while rk_valid=1.
- Handshake: transfer when rk_valid && rk_ready.
  - rk_data, rk_round and rk_last hold stable while rk_valid && !rk_ready.
  - rk_valid never deasserts without a transfer, except on load or rst.
- After a transfer, r--. If the transferred round was 0, go to IDLE with busy=0 the next cycle.
- Latency from load (cycle 0): round Nr valid at cycle FWD_len+1, i.e. cycle 41 for Nk=4.
- Each subsequent round is valid at most 5 cycles after the previous transfer (4 steps + register). If its words are already in the window, it is valid the cycle after.
- The backward recurrence never steps below b=0, and round 0 equals the input key.
- EQ_INV=1: InvMixColumns is applied combinationally before the rk_data register, for rounds 1..Nr-1 only. Rounds 0 and Nr are never transformed.
- load while busy: abort, drop rk_valid the next cycle, restart FWD with the new key. load in the same cycle as a transfer: the transfer completes, then restart.
- rst mid-operation: return to the reset values the next cycle; load is ignored in the rst cycle.
- rk_ready held high: rounds stream with no stalls beyond the step latency.

Decomposition:
- aes_pkg already holds SubWord, RotWord and RCON.
- Add InvMixColumnsWord (single 32-bit column) to aes_pkg.
- Add the function KeyTemp(word, idx, Nk) to aes_pkg. It gives the forward/backward f term, shared by both directions.
- One combinational sub-module, aes_key_word_step. Inputs: w_far, w_near, idx. Output: w_far ^ KeyTemp(w_near, idx). Used for both FWD and REV.

Test Plan:
- Nk=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c (w0..w3), rk_ready=1 -> first output round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 at cycle 41; last output round 0 equals the key with rk_last=1; 11 transfers total.
- Nk=6, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> round 12 = e98ba06f 448c773c 8ecc7204 01002202; rounds continue down to round 0 = w0..w3 of the key.
- Nk=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> round 14 = fe4890d1 e6188d0b 046df344 706c631e; round 13 is valid the cycle after the round-14 transfer.
- Backpressure: rk_ready toggling 1010.., and held low 7 cycles at round 5 -> data and round stable while stalled, no round skipped or duplicated, order 10..0.
- Abort: load a new key at cycle 20 of FWD, then rst asserted during REV -> the new key's round 10 appears at cycle 41 after the second load; after rst, outputs are at reset values the next cycle.
- EQ_INV=1, Nk=4 FIPS key -> rounds 10 and 0 unchanged; round 9 equals InvMixColumnsWord applied per word to the forward round-9 key.
